// File: rtl/urng_pkg.sv
// Shared constants, types and the taus88 step function for the uniform pair generator.
package urng_pkg;

  // Default seeds for the three taus88 state words
  localparam logic [31:0] SEED0_DEF = 32'h1234_5678;
  localparam logic [31:0] SEED1_DEF = 32'h9E37_79B9;
  localparam logic [31:0] SEED2_DEF = 32'hBA51_980D;

  // taus88 shift constants: feedback left, feedback right, state left
  localparam int unsigned S0_A = 13, S0_B = 19, S0_C = 12;
  localparam int unsigned S1_A = 2,  S1_B = 25, S1_C = 4;
  localparam int unsigned S2_A = 3,  S2_B = 11, S2_C = 17;

  // Bits forced on at every state load so no word drops below its minimum
  localparam logic [31:0] S0_MIN = 32'd2;
  localparam logic [31:0] S1_MIN = 32'd8;
  localparam logic [31:0] S2_MIN = 32'd16;

  // Low-bit clear masks applied before the state shift
  localparam logic [31:0] S0_CLR = 32'hFFFF_FFFE;
  localparam logic [31:0] S1_CLR = 32'hFFFF_FFF8;
  localparam logic [31:0] S2_CLR = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {S_WARM, S_GEN_A, S_GEN_B, S_OUT} urng_state_e;

  typedef struct packed {
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s2;
  } taus_state_t;

  // One combined-Tausworthe step; all shifts are logical on 32-bit words
  function automatic taus_state_t taus88_step(input taus_state_t s);
    taus_state_t n;
    logic [31:0] b;
    b    = ((s.s0 << S0_A) ^ s.s0) >> S0_B;
    n.s0 = ((s.s0 & S0_CLR) << S0_C) ^ b;
    b    = ((s.s1 << S1_A) ^ s.s1) >> S1_B;
    n.s1 = ((s.s1 & S1_CLR) << S1_C) ^ b;
    b    = ((s.s2 << S2_A) ^ s.s2) >> S2_B;
    n.s2 = ((s.s2 & S2_CLR) << S2_C) ^ b;
    return n;
  endfunction

endpackage

// File: rtl/taus88_core.sv
// taus88 state holder: three 32-bit words, load with minimum-bit guard, step on demand.
// word is the output of the step that step_en would commit on the next edge.
module taus88_core
  import urng_pkg::*;
#(
  parameter logic [31:0] SEED0 = SEED0_DEF,
  parameter logic [31:0] SEED1 = SEED1_DEF,
  parameter logic [31:0] SEED2 = SEED2_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_en,
  input  logic        load_en,
  input  logic [31:0] load_s0,
  input  logic [31:0] load_s1,
  input  logic [31:0] load_s2,
  output logic [31:0] word
);

  taus_state_t st, nxt;

  assign nxt  = taus88_step(st);
  assign word = nxt.s0 ^ nxt.s1 ^ nxt.s2;

  // State register: reset to guarded seeds, load beats step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st.s0 <= SEED0 | S0_MIN;
      st.s1 <= SEED1 | S1_MIN;
      st.s2 <= SEED2 | S2_MIN;
    end else if (load_en) begin
      st.s0 <= load_s0 | S0_MIN;
      st.s1 <= load_s1 | S1_MIN;
      st.s2 <= load_s2 | S2_MIN;
    end else if (step_en) begin
      st <= nxt;
    end
  end

endmodule

// File: rtl/taus_urng_pair.sv
// Uniform pair source for the Box-Muller datapath: warm-up, two steps per pair,
// valid/ready output held on stall, runtime reseed.
// Optional macro URNG_ZERO_GUARD_EN: substitute 1 for a zero u0 word.
module taus_urng_pair
  import urng_pkg::*;
#(
  parameter logic [31:0] SEED0  = SEED0_DEF,
  parameter logic [31:0] SEED1  = SEED1_DEF,
  parameter logic [31:0] SEED2  = SEED2_DEF,
  parameter int unsigned WARMUP = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        seed_load,
  input  logic [31:0] seed_in,
  input  logic        u_ready,
  output logic        u_valid,
  output logic [31:0] u0,
  output logic [15:0] u1,
  output logic        busy
);

  localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);

  urng_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        step_en, lat_u0, lat_u1, set_vld, clr_vld;
  logic [31:0] word, u0_word;

  taus88_core #(
    .SEED0 (SEED0),
    .SEED1 (SEED1),
    .SEED2 (SEED2)
  ) u_core (
    .clk     (clk),
    .rst     (reset),
    .step_en (step_en),
    .load_en (seed_load),
    .load_s0 (seed_in),
    .load_s1 (seed_in ^ SEED1),
    .load_s2 (seed_in ^ SEED2),
    .word    (word)
  );

`ifdef URNG_ZERO_GUARD_EN
  // log path must never see ln(0)
  assign u0_word = (word == 32'h0) ? 32'h1 : word;
`else
  assign u0_word = word;
`endif

  assign busy = (state_q == S_WARM);

  // Next-state and datapath controls; reseed overrides everything, handshake ignores enable
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_en = 1'b0;
    lat_u0  = 1'b0;
    lat_u1  = 1'b0;
    set_vld = 1'b0;
    clr_vld = 1'b0;
    if (seed_load) begin
      state_d = S_WARM;
      cnt_d   = 16'd0;
      clr_vld = 1'b1;
    end else begin
      case (state_q)
        S_WARM: if (enable) begin
          step_en = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          if (cnt_q == WARM_LAST) state_d = S_GEN_A;
        end
        S_GEN_A: if (enable) begin
          step_en = 1'b1;
          lat_u0  = 1'b1;
          state_d = S_GEN_B;
        end
        S_GEN_B: if (enable) begin
          step_en = 1'b1;
          lat_u1  = 1'b1;
          set_vld = 1'b1;
          state_d = S_OUT;
        end
        // S_GEN_A waits for enable itself, so the handshake can always go there
        S_OUT: if (u_valid && u_ready) begin
          clr_vld = 1'b1;
          state_d = S_GEN_A;
        end
        default: state_d = S_WARM;
      endcase
    end
  end

  // FSM state and warm-up counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WARM;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output pair registers; stable while waiting in S_OUT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u_valid <= 1'b0;
      u0      <= 32'h0;
      u1      <= 16'h0;
    end else begin
      if (lat_u0) u0 <= u0_word;
      if (lat_u1) u1 <= word[31:16];
      if (clr_vld)      u_valid <= 1'b0;
      else if (set_vld) u_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_taus_urng_pair.sv
// Randomized bench for taus_urng_pair against a word-sequence / cycle-budget model.
module tb_taus_urng_pair;

  localparam logic [31:0] SEED0 = 32'h1234_5678;
  localparam logic [31:0] SEED1 = 32'h9E37_79B9;
  localparam logic [31:0] SEED2 = 32'hBA51_980D;
  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0, seed_load = 1'b0, u_ready = 1'b0;
  logic [31:0] seed_in = 32'h0;
  logic        u_valid, busy;
  logic [31:0] u0;
  logic [15:0] u1;

  taus_urng_pair dut (
    .clk(clk), .reset(rst), .enable(enable), .seed_load(seed_load),
    .seed_in(seed_in), .u_ready(u_ready), .u_valid(u_valid),
    .u0(u0), .u1(u1), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: word stream + enabled-edge budget ----
  int unsigned sh_l[3] = '{13, 2, 3};
  int unsigned sh_r[3] = '{19, 25, 11};
  int unsigned sh_s[3] = '{12, 4, 17};
  logic [31:0] low_bits[3] = '{32'd1, 32'd7, 32'd15};
  logic [31:0] m[3];
  logic [31:0] exp_u0, exp_u1;
  logic        exp_valid;
  int          need;

  task automatic model_word(output logic [31:0] w);
    logic [31:0] z, fb;
    w = 32'h0;
    for (int k = 0; k < 3; k++) begin
      z    = m[k];
      fb   = ((z << sh_l[k]) ^ z) >> sh_r[k];
      m[k] = ((z & ~low_bits[k]) << sh_s[k]) ^ fb;
      w    = w ^ m[k];
    end
  endtask

  task automatic model_seed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [31:0] w;
    m[0] = a | 32'd2;
    m[1] = b | 32'd8;
    m[2] = c | 32'd16;
    for (int i = 0; i < W; i++) model_word(w);
    need = W + 2;
    exp_valid = 1'b0;
  endtask

  task automatic next_pair();
    logic [31:0] w;
    model_word(w);
`ifdef URNG_ZERO_GUARD_EN
    exp_u0 = (w == 32'h0) ? 32'h1 : w;
`else
    exp_u0 = w;
`endif
    model_word(w);
    exp_u1 = {16'h0, w[31:16]};
  endtask

  // one clock: check outputs (at negedge), drive inputs, advance model across the next posedge
  task automatic cyc(input logic en, input logic rdy, input logic ld, input logic [31:0] sd);
    chk("u_valid", u_valid, exp_valid);
    chk("busy", busy, (!exp_valid && need > 2));
    if (exp_valid) begin
      chk("u0", u0, exp_u0);
      chk("u1", u1, exp_u1);
    end
    enable = en; u_ready = rdy; seed_load = ld; seed_in = sd;
    if (ld) model_seed(sd, sd ^ SEED1, sd ^ SEED2);
    else if (exp_valid && rdy) begin exp_valid = 1'b0; need = 2; end
    else if (!exp_valid && en) begin
      need--;
      if (need == 0) begin exp_valid = 1'b1; next_pair(); end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; seed_load = 1'b0; u_ready = 1'b0; seed_in = 32'h0;
    #1;
    chk("rst_valid", u_valid, 32'h0);
    chk("rst_busy", busy, 32'h1);
    chk("rst_u0", u0, 32'h0);
    chk("rst_u1", u1, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_seed(SEED0, SEED1, SEED2);
  endtask

  initial begin
    int edges;
    do_reset();

    // first pair latency with enable/ready high
    edges = 0;
    while (!u_valid && edges < 100) begin cyc(1, 1, 0, 0); edges++; end
    chk("first_valid_edge", edges, W + 2);
    repeat (12) cyc(1, 1, 0, 0);

    // backpressure: hold 10 cycles while a pair is offered
    edges = 0;
    while (!u_valid && edges < 10) begin cyc(1, 1, 0, 0); edges++; end
    repeat (10) cyc(1, 0, 0, 0);
    repeat (9) cyc(1, 1, 0, 0);

    // reseed with zero, coinciding with an accepted pair
    edges = 0;
    while (!u_valid && edges < 10) begin cyc(1, 1, 0, 0); edges++; end
    cyc(1, 1, 1, 32'h0);
    chk("seed_discard_valid", u_valid, 32'h0);
    chk("seed_busy", busy, 32'h1);
    edges = 0;
    while (!u_valid && edges < 100) begin cyc(1, 1, 0, 0); edges++; end
    chk("reseed_latency", edges, W + 2);
    repeat (6) cyc(1, 1, 0, 0);

    // enable low for 5 cycles mid warm-up delays the pair by exactly 5
    cyc(1, 1, 1, 32'hCAFE_F00D);
    edges = 0;
    repeat (3) begin cyc(1, 1, 0, 0); edges++; end
    repeat (5) begin cyc(0, 1, 0, 0); edges++; end
    while (!u_valid && edges < 100) begin cyc(1, 1, 0, 0); edges++; end
    chk("stall_warm_latency", edges, W + 2 + 5);

    // randomized traffic with occasional reseed and one mid-run reset
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) do_reset();
      cyc(($urandom % 100) < 85, ($urandom % 100) < 65, ($urandom % 200) == 0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
